// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module   : nibble_serial_adder
// Brief    : WIDTH-bit adder time-multiplexed over one 4-bit G/P lookahead
//            slice, LSB nibble first. Define NIBBLE_SERIAL_ADDER_SUB_EN to add
//            the sub input and the signed-overflow output ovf.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_raw;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [4:0]       w_c;
    logic [3:0]       w_sum;

    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_raw = r_b[{r_idx, 2'b00} +: 4];

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic r_sub;
    assign w_b_nib = r_sub ? ~w_b_raw : w_b_raw;
    assign ovf     = r_ovf;
`else
    assign w_b_nib = w_b_raw;
`endif

    // Carry lookahead across the slice; w_c[3] is the carry into the nibble MSB.
    assign w_g    = w_a_nib & w_b_nib;
    assign w_p    = w_a_nib ^ w_b_nib;
    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_sum  = w_p ^ w_c[3:0];

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_idx <= '0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
                        r_sub   <= sub;
                        r_carry <= sub ? 1'b1 : cin;
`else
                        r_carry <= cin;
`endif
                    end
                end
                RUN: begin
                    r_s[{r_idx, 2'b00} +: 4] <= w_sum;
                    r_carry                  <= w_c[4];
                    r_idx                    <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_cout <= w_c[4];
                        r_ovf  <= w_c[3] ^ w_c[4];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign s    = r_s;
    assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module   : tb_nibble_serial_adder
// Brief    : Scoreboard bench for nibble_serial_adder; honours
//            NIBBLE_SERIAL_ADDER_SUB_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct packed {
        logic         ovf;
        logic         cout;
        logic [W-1:0] s;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         busy;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic         sub;
    logic         ovf;
`endif

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .sub       (sub),
        .ovf       (ovf),
`endif
        .s         (s),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_pass  = 0;
    int   n_total = 0;
    res_t exp_q[$];
    int   acc_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference: plain unsigned/signed integer arithmetic on whole operands.
    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mcin, input logic msub);
        res_t         r;
        logic [W:0]   full;
        longint       sa, sb, sr;
        longint       smax, smin;
        sa   = longint'($signed(ma));
        sb   = longint'($signed(mb));
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        if (msub) begin
            r.s    = ma - mb;
            r.cout = (ma >= mb);
            sr     = sa - sb;
        end else begin
            full   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
            r.s    = full[W-1:0];
            r.cout = full[W];
            sr     = sa + sb + longint'(mcin);
        end
        r.ovf = (sr > smax) || (sr < smin);
        return r;
    endfunction

    // Monitor: sampled on the falling edge, well away from the active edge.
    logic mon_en   = 1'b0;
    logic inflight = 1'b0;
    logic prev_ov  = 1'b0;
    logic prev_ord = 1'b0;
    res_t held;
    res_t e;
    int   lat;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                inflight = 1'b0;
                prev_ov  = 1'b0;
            end else begin
                check("busy", busy, inflight);
                check("in_ready", in_ready, !inflight);
                if (out_valid && !prev_ov) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out_valid", out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sum", s, e.s);
                        check("cout", cout, e.cout);
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
                        check("ovf", ovf, e.ovf);
`endif
                        held = e;
                        if (acc_q.size() != 0) begin
                            lat = cyc - acc_q.pop_front();
                            check("latency", lat, NIB);
                        end
                    end
                end else if (out_valid && prev_ov) begin
                    if (prev_ord) check("drop_after_ready", out_valid, 0);
                    check("hold_s", s, held.s);
                    check("hold_cout", cout, held.cout);
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
                    check("hold_ovf", ovf, held.ovf);
`endif
                end
                if (in_valid && in_ready) begin
                    acc_q.push_back(cyc + 1);
                    inflight = 1'b1;
                end
                if (out_valid && out_ready) inflight = 1'b0;
                prev_ov  = out_valid;
                prev_ord = out_ready;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tcin, input logic tsub);
        int n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
            return;
        end
        a        = ta;
        b        = tb;
        cin      = tcin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        sub      = tsub;
`endif
        in_valid = 1'b1;
        exp_q.push_back(model(ta, tb, tcin, tsub));
        step();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) check("idle_timeout", n, 0);
    endtask

    initial begin
        int n;
        logic rs;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        repeat (3) step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_s", s, 0);
        check("rst_cout", cout, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_idle();
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_idle();

        // Back-to-back: second op must not inherit the first op's carry.
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_idle();

        // Backpressure with an ignored input pulse while DONE.
        out_ready = 1'b0;
        do_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        check("bp_reached_done", out_valid, 1);
        step();
        in_valid = 1'b1;
        a        = 16'h0F0F;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        check("bp_still_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        check("bp_released_valid", out_valid, 0);
        check("bp_released_ready", in_ready, 1);
        wait_idle();

        // Reset two cycles into RUN aborts the operation.
        do_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete();
        acc_q.delete();
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_s", s, 0);
        check("abort_cout", cout, 0);
        repeat (8) step();

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_idle();
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1);
        wait_idle();
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_idle();
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op(W'($urandom), W'($urandom), 1'($urandom), rs);
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'b0;
                repeat ($urandom_range(NIB, NIB + 4)) step();
                out_ready = 1'b1;
            end
        end
        wait_idle();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
